// File: rtl/xsim_dma_pkg.sv
// Shared types and constants for the simulation DMA burst reader.
// Word size, handle/address types and the issue FSM encoding.
package xsim_dma_pkg;

    localparam int WORD_BYTES = 4;

    typedef logic [31:0] dma_handle_t;
    typedef logic [31:0] dma_addr_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } burst_state_e;

    function automatic logic [13:0] len_to_words(input logic [15:0] len);
        return len[15:2];
    endfunction

endpackage

// File: rtl/xsim_dma_fwft_fifo.sv
// First-word-fall-through FIFO with occupancy count.
// Head entry is always visible on rdata; storage clears to zero on reset.
module xsim_dma_fwft_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     enq,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     deq,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_enq;
    logic             do_deq;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign count  = count_q;
    assign rdata  = mem_q[rptr_q];
    // A full FIFO may still accept when its head leaves in the same cycle
    assign do_deq = deq && !empty;
    assign do_enq = enq && (!full || do_deq);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_enq) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_deq) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_q + CW'(do_enq) - CW'(do_deq);
        end
    end

endmodule

// File: rtl/xsim_dma_burst_reader.sv
// Splits byte-length read bursts into word reads on the DMA port and
// returns tagged words through a credit-protected output buffer.
module xsim_dma_burst_reader
    import xsim_dma_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic             CLK,
    input  logic             RST,
    output logic             rdy_burst,
    input  logic             en_burst,
    input  logic [31:0]      burst_handle,
    input  logic [31:0]      burst_addr,
    input  logic [15:0]      burst_len,
    input  logic [TAG_W-1:0] burst_tag,
    input  logic             rdy_readrequest,
    output logic             en_readrequest,
    output logic [31:0]      readrequest_addr,
    output logic [31:0]      readrequest_handle,
    input  logic             rdy_readresponse,
    output logic             en_readresponse,
    input  logic [31:0]      readresponse_data,
    output logic             rdy_data,
    input  logic             en_data,
    output logic [31:0]      data_word,
    output logic [TAG_W-1:0] data_tag,
    output logic             data_last
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int SIDE_W = TAG_W + 1;
    localparam int OUT_W  = 32 + SIDE_W;

    burst_state_e     state_q, state_d;
    dma_handle_t      handle_q, handle_d;
    dma_addr_t        addr_q, addr_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [13:0]      left_q, left_d;
    logic [CW-1:0]    outst_q, outst_d;

    logic             credit_ok;
    logic             resp_take;
    logic [13:0]      req_words;

    logic [SIDE_W-1:0] side_wdata;
    logic [SIDE_W-1:0] side_rdata;
    logic              side_full;
    logic              side_empty;
    logic [CW-1:0]     side_count;

    logic [OUT_W-1:0]  out_rdata;
    logic              out_full;
    logic              out_empty;
    logic [CW-1:0]     out_count;

    assign req_words = len_to_words(burst_len);
    // Reserve a buffer slot for every read still in flight
    assign credit_ok = ({1'b0, outst_q} + {1'b0, out_count}) < (CW + 1)'(DEPTH);
    assign en_readresponse = rdy_readresponse && !RST;
    // Responses arriving with nothing outstanding are leftovers from a reset
    assign resp_take = en_readresponse && (outst_q != '0);

    assign readrequest_addr   = addr_q;
    assign readrequest_handle = handle_q;
    assign side_wdata         = {tag_q, left_q == 14'd1};

    assign rdy_data  = !out_empty;
    assign data_word = out_rdata[OUT_W-1 -: 32];
    assign data_tag  = out_rdata[TAG_W:1];
    assign data_last = out_rdata[0];

    always_comb begin
        state_d        = state_q;
        handle_d       = handle_q;
        addr_d         = addr_q;
        tag_d          = tag_q;
        left_d         = left_q;
        rdy_burst      = 1'b0;
        en_readrequest = 1'b0;
        unique case (state_q)
            IDLE: begin
                rdy_burst = !RST;
                if (en_burst && rdy_burst && req_words != '0) begin
                    handle_d = burst_handle;
                    addr_d   = {burst_addr[31:2], 2'b00};
                    tag_d    = burst_tag;
                    left_d   = req_words;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                en_readrequest = rdy_readrequest && credit_ok;
                if (en_readrequest) begin
                    addr_d = addr_q + 32'(WORD_BYTES);
                    left_d = left_q - 14'd1;
                    if (left_q == 14'd1) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
        outst_d = outst_q + CW'(en_readrequest) - CW'(resp_take);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            handle_q <= '0;
            addr_q   <= '0;
            tag_q    <= '0;
            left_q   <= '0;
            outst_q  <= '0;
        end else begin
            state_q  <= state_d;
            handle_q <= handle_d;
            addr_q   <= addr_d;
            tag_q    <= tag_d;
            left_q   <= left_d;
            outst_q  <= outst_d;
        end
    end

    xsim_dma_fwft_fifo #(
        .WIDTH (SIDE_W),
        .DEPTH (DEPTH)
    ) u_side_q (
        .CLK   (CLK),
        .RST   (RST),
        .enq   (en_readrequest),
        .wdata (side_wdata),
        .deq   (resp_take),
        .rdata (side_rdata),
        .full  (side_full),
        .empty (side_empty),
        .count (side_count)
    );

    xsim_dma_fwft_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_out_q (
        .CLK   (CLK),
        .RST   (RST),
        .enq   (resp_take),
        .wdata ({readresponse_data, side_rdata}),
        .deq   (en_data),
        .rdata (out_rdata),
        .full  (out_full),
        .empty (out_empty),
        .count (out_count)
    );

    always @(posedge CLK) begin
        if (!RST) begin
            assert (!(en_burst && !rdy_burst))
                else $error("en_burst while not ready; ignored");
            assert (!(en_burst && rdy_burst && (burst_addr[1:0] != 2'b00 || burst_len[1:0] != 2'b00)))
                else $error("unaligned burst addr/len; low bits truncated");
            assert (!(en_data && !rdy_data))
                else $error("en_data while buffer empty; ignored");
            assert (!(en_readrequest && side_full))
                else $error("in-flight queue overflow");
            assert (!(resp_take && side_empty))
                else $error("response without in-flight entry");
            assert (side_count == outst_q)
                else $error("in-flight queue out of step with outstanding");
            assert (!(resp_take && out_full && !en_data))
                else $error("output buffer overflow");
        end
    end

endmodule

// File: tb/tb_xsim_dma_burst_reader.sv
// Randomized self-checking bench for xsim_dma_burst_reader with a
// queue-based DMA port model and a per-burst reference model.
module tb_xsim_dma_burst_reader;

    localparam int DEPTH = 4;
    localparam int TAG_W = 6;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] handle;
    } req_t;

    typedef struct packed {
        logic [31:0]      word;
        logic [TAG_W-1:0] tag;
        logic             last;
    } out_t;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             rdy_burst;
    logic             en_burst = 1'b0;
    logic [31:0]      burst_handle = '0;
    logic [31:0]      burst_addr = '0;
    logic [15:0]      burst_len = '0;
    logic [TAG_W-1:0] burst_tag = '0;
    logic             rdy_readrequest = 1'b0;
    logic             en_readrequest;
    logic [31:0]      readrequest_addr;
    logic [31:0]      readrequest_handle;
    logic             rdy_readresponse = 1'b0;
    logic             en_readresponse;
    logic [31:0]      readresponse_data = '0;
    logic             rdy_data;
    logic             en_data;
    logic [31:0]      data_word;
    logic [TAG_W-1:0] data_tag;
    logic             data_last;

    int passed = 0;
    int total = 0;
    int timeouts = 0;

    req_t        req_log[$];
    req_t        exp_req[$];
    out_t        out_log[$];
    out_t        exp_out[$];
    logic [31:0] dma_q[$];

    bit          fire_req = 0;
    bit          fire_resp = 0;
    logic [31:0] fire_addr = '0;
    int          rr_mode = 0;
    bit          cons_en = 0;
    bit          cons_rand = 0;

    assign en_data = cons_en & rdy_data;

    xsim_dma_burst_reader #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .CLK                (CLK),
        .RST                (RST),
        .rdy_burst          (rdy_burst),
        .en_burst           (en_burst),
        .burst_handle       (burst_handle),
        .burst_addr         (burst_addr),
        .burst_len          (burst_len),
        .burst_tag          (burst_tag),
        .rdy_readrequest    (rdy_readrequest),
        .en_readrequest     (en_readrequest),
        .readrequest_addr   (readrequest_addr),
        .readrequest_handle (readrequest_handle),
        .rdy_readresponse   (rdy_readresponse),
        .en_readresponse    (en_readresponse),
        .readresponse_data  (readresponse_data),
        .rdy_data           (rdy_data),
        .en_data            (en_data),
        .data_word          (data_word),
        .data_tag           (data_tag),
        .data_last          (data_last)
    );

    always #5 CLK = ~CLK;

    // Observe handshakes mid-cycle; they complete at the next rising edge
    always @(negedge CLK) begin
        fire_req  = en_readrequest;
        fire_addr = readrequest_addr;
        fire_resp = en_readresponse && rdy_readresponse;
        if (en_readrequest) req_log.push_back('{readrequest_addr, readrequest_handle});
        if (en_data) out_log.push_back('{data_word, data_tag, data_last});
    end

    // DMA port: a word requested in one cycle is presented in the next
    always @(posedge CLK) begin
        #1;
        if (fire_resp && dma_q.size() > 0) void'(dma_q.pop_front());
        if (fire_req) dma_q.push_back(fire_addr ^ 32'h0000_FFFF);
        fire_req  = 0;
        fire_resp = 0;
        rdy_readresponse  = (dma_q.size() > 0);
        readresponse_data = (dma_q.size() > 0) ? dma_q[0] : 32'h0;
        case (rr_mode)
            0: rdy_readrequest = 1'b1;
            1: rdy_readrequest = ~rdy_readrequest;
            default: rdy_readrequest = 1'($urandom_range(0, 1));
        endcase
        if (cons_rand) cons_en = 1'($urandom_range(0, 1));
    end

    task automatic clear_logs();
        req_log.delete();
        exp_req.delete();
        out_log.delete();
        exp_out.delete();
    endtask

    task automatic send_burst(input logic [31:0] h, input logic [31:0] a,
                              input logic [15:0] l, input logic [TAG_W-1:0] t);
        int n;
        int c;
        logic [31:0] wa;
        n = int'(l) / 4;
        for (int i = 0; i < n; i++) begin
            wa = a + 32'(4 * i);
            exp_req.push_back('{wa, h});
            exp_out.push_back('{wa ^ 32'h0000_FFFF, t, (i == n - 1)});
        end
        @(negedge CLK);
        c = 0;
        while (!rdy_burst && c < 1000) begin
            @(negedge CLK);
            c++;
        end
        if (!rdy_burst) timeouts++;
        burst_handle = h;
        burst_addr   = a;
        burst_len    = l;
        burst_tag    = t;
        en_burst     = 1'b1;
        @(posedge CLK);
        #1 en_burst = 1'b0;
    endtask

    task automatic drain(input int n);
        int c;
        c = 0;
        while (out_log.size() < n && c < 2000) begin
            @(negedge CLK);
            c++;
        end
        if (out_log.size() < n) timeouts++;
        repeat (6) @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        total++;
        if ({rdy_burst, en_readrequest, en_readresponse, rdy_data} !== 4'b0000)
            $display("FAIL reset_ctrl got %b want 0000",
                     {rdy_burst, en_readrequest, en_readresponse, rdy_data});
        else passed++;
        total++;
        if ({readrequest_addr, readrequest_handle} !== 64'h0)
            $display("FAIL reset_req got %h/%h want 0/0", readrequest_addr, readrequest_handle);
        else passed++;
        total++;
        if ({data_word, data_tag, data_last} !== '0)
            $display("FAIL reset_data got %h/%h/%b want 0", data_word, data_tag, data_last);
        else passed++;
        RST = 1'b0;
        @(negedge CLK);
        total++;
        if (rdy_burst !== 1'b1) $display("FAIL reset_release rdy_burst got %b want 1", rdy_burst);
        else passed++;
    endtask

    task automatic test_single();
        logic [31:0] lit [4];
        lit = '{32'hFEFF, 32'hFEFB, 32'hFEF7, 32'hFEF3};
        clear_logs();
        rr_mode = 0;
        @(posedge CLK);
        #1 cons_en = 1'b1;
        send_burst(32'd5, 32'h100, 16'd16, 6'd3);
        drain(4);
        total++;
        if (req_log.size() != exp_req.size())
            $display("FAIL single_req_count got %0d want %0d", req_log.size(), exp_req.size());
        else passed++;
        foreach (exp_req[i]) if (i < req_log.size()) begin
            total++;
            if (req_log[i] !== exp_req[i])
                $display("FAIL single_req[%0d] got %h want %h", i, req_log[i], exp_req[i]);
            else passed++;
        end
        total++;
        if (out_log.size() != 4) $display("FAIL single_out_count got %0d want 4", out_log.size());
        else passed++;
        foreach (out_log[i]) if (i < 4) begin
            total++;
            if (out_log[i] !== exp_out[i] || out_log[i].word !== lit[i])
                $display("FAIL single_out[%0d] got %h want %h", i, out_log[i], exp_out[i]);
            else passed++;
        end
        total++;
        if (timeouts != 0) $display("FAIL single_timeout got %0d want 0", timeouts);
        else passed++;
        timeouts = 0;
    endtask

    task automatic test_backpressure();
        clear_logs();
        rr_mode = 0;
        @(posedge CLK);
        #1 cons_en = 1'b0;
        send_burst(32'd1, 32'h200, 16'd32, 6'd4);
        repeat (20) @(negedge CLK);
        total++;
        if (req_log.size() != DEPTH)
            $display("FAIL bp_stall_reqs got %0d want %0d", req_log.size(), DEPTH);
        else passed++;
        total++;
        if (en_readrequest !== 1'b0) $display("FAIL bp_stall_en got %b want 0", en_readrequest);
        else passed++;
        @(posedge CLK);
        #1 cons_en = 1'b1;
        @(posedge CLK);
        #1 cons_en = 1'b0;
        repeat (10) @(negedge CLK);
        total++;
        if (req_log.size() != DEPTH + 1)
            $display("FAIL bp_one_more got %0d want %0d", req_log.size(), DEPTH + 1);
        else passed++;
        @(posedge CLK);
        #1 cons_en = 1'b1;
        drain(8);
        total++;
        if (out_log.size() != exp_out.size() || req_log.size() != exp_req.size())
            $display("FAIL bp_counts got %0d/%0d want %0d/%0d", out_log.size(), req_log.size(),
                     exp_out.size(), exp_req.size());
        else passed++;
        foreach (exp_out[i]) if (i < out_log.size()) begin
            total++;
            if (out_log[i] !== exp_out[i])
                $display("FAIL bp_out[%0d] got %h want %h", i, out_log[i], exp_out[i]);
            else passed++;
        end
        total++;
        if (timeouts != 0) $display("FAIL bp_timeout got %0d want 0", timeouts);
        else passed++;
        timeouts = 0;
    endtask

    task automatic test_wrap_zero();
        logic [31:0] lit [4];
        lit = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        clear_logs();
        send_burst(32'd7, 32'hFFFF_FFF8, 16'd16, 6'd5);
        drain(4);
        total++;
        if (req_log.size() != 4) $display("FAIL wrap_req_count got %0d want 4", req_log.size());
        else passed++;
        foreach (req_log[i]) if (i < 4) begin
            total++;
            if (req_log[i].addr !== lit[i] || req_log[i] !== exp_req[i])
                $display("FAIL wrap_req[%0d] got %h want %h", i, req_log[i].addr, lit[i]);
            else passed++;
        end
        foreach (exp_out[i]) if (i < out_log.size()) begin
            total++;
            if (out_log[i] !== exp_out[i])
                $display("FAIL wrap_out[%0d] got %h want %h", i, out_log[i], exp_out[i]);
            else passed++;
        end
        clear_logs();
        send_burst(32'd7, 32'h1000, 16'd0, 6'd9);
        repeat (10) @(negedge CLK);
        total++;
        if (req_log.size() != 0 || out_log.size() != 0)
            $display("FAIL zero_len got %0d reqs %0d words want 0 0", req_log.size(), out_log.size());
        else passed++;
        total++;
        if (rdy_burst !== 1'b1) $display("FAIL zero_len_rdy got %b want 1", rdy_burst);
        else passed++;
        total++;
        if (timeouts != 0) $display("FAIL wrap_timeout got %0d want 0", timeouts);
        else passed++;
        timeouts = 0;
    endtask

    task automatic test_back_to_back();
        logic [TAG_W-1:0] tags [3];
        logic             lasts [3];
        tags  = '{6'd1, 6'd1, 6'd2};
        lasts = '{1'b0, 1'b1, 1'b1};
        clear_logs();
        rr_mode = 1;
        send_burst(32'd2, 32'h40, 16'd8, 6'd1);
        send_burst(32'd2, 32'h80, 16'd4, 6'd2);
        drain(3);
        rr_mode = 0;
        total++;
        if (out_log.size() != 3) $display("FAIL b2b_count got %0d want 3", out_log.size());
        else passed++;
        foreach (out_log[i]) if (i < 3) begin
            total++;
            if (out_log[i].tag !== tags[i] || out_log[i].last !== lasts[i] || out_log[i] !== exp_out[i])
                $display("FAIL b2b_out[%0d] got %h want %h", i, out_log[i], exp_out[i]);
            else passed++;
        end
        total++;
        if (timeouts != 0) $display("FAIL b2b_timeout got %0d want 0", timeouts);
        else passed++;
        timeouts = 0;
    endtask

    task automatic test_random();
        logic [31:0] h;
        logic [31:0] a;
        logic [15:0] l;
        clear_logs();
        rr_mode   = 2;
        cons_rand = 1;
        for (int b = 0; b < 8; b++) begin
            h = $urandom;
            a = $urandom & 32'hFFFF_FFFC;
            if (b == 3) a = 32'hFFFF_FFF0;
            l = 16'($urandom_range(0, 10) * 4);
            send_burst(h, a, l, TAG_W'($urandom));
        end
        drain(exp_out.size());
        rr_mode   = 0;
        cons_rand = 0;
        @(posedge CLK);
        #1 cons_en = 1'b1;
        total++;
        if (req_log.size() != exp_req.size() || out_log.size() != exp_out.size())
            $display("FAIL rand_counts got %0d/%0d want %0d/%0d", req_log.size(), out_log.size(),
                     exp_req.size(), exp_out.size());
        else passed++;
        foreach (exp_req[i]) if (i < req_log.size()) begin
            total++;
            if (req_log[i] !== exp_req[i])
                $display("FAIL rand_req[%0d] got %h want %h", i, req_log[i], exp_req[i]);
            else passed++;
        end
        foreach (exp_out[i]) if (i < out_log.size()) begin
            total++;
            if (out_log[i] !== exp_out[i])
                $display("FAIL rand_out[%0d] got %h want %h", i, out_log[i], exp_out[i]);
            else passed++;
        end
        total++;
        if (timeouts != 0) $display("FAIL rand_timeout got %0d want 0", timeouts);
        else passed++;
        timeouts = 0;
    endtask

    task automatic test_reset_mid();
        int c;
        clear_logs();
        rr_mode = 0;
        send_burst(32'd3, 32'h300, 16'd16, 6'd6);
        c = 0;
        while (req_log.size() < 2 && c < 100) begin
            @(negedge CLK);
            c++;
        end
        if (req_log.size() < 2) timeouts++;
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        total++;
        if ({rdy_burst, en_readrequest, en_readresponse, rdy_data} !== 4'b0000)
            $display("FAIL midrst_ctrl got %b want 0000",
                     {rdy_burst, en_readrequest, en_readresponse, rdy_data});
        else passed++;
        total++;
        if ({readrequest_addr, readrequest_handle, data_word, data_tag, data_last} !== '0)
            $display("FAIL midrst_vals got %h/%h/%h want 0", readrequest_addr, data_word, data_tag);
        else passed++;
        RST = 1'b0;
        clear_logs();
        repeat (4) @(negedge CLK);
        total++;
        if (dma_q.size() != 0 || out_log.size() != 0)
            $display("FAIL midrst_discard got %0d pending %0d words want 0 0", dma_q.size(),
                     out_log.size());
        else passed++;
        clear_logs();
        send_burst(32'd3, 32'h400, 16'd4, 6'd7);
        drain(1);
        total++;
        if (out_log.size() != 1) $display("FAIL midrst_count got %0d want 1", out_log.size());
        else passed++;
        if (out_log.size() > 0) begin
            total++;
            if (out_log[0] !== exp_out[0] || out_log[0].word !== 32'hFBFF || out_log[0].last !== 1'b1)
                $display("FAIL midrst_word got %h want %h", out_log[0], exp_out[0]);
            else passed++;
        end
        total++;
        if (timeouts != 0) $display("FAIL midrst_timeout got %0d want 0", timeouts);
        else passed++;
        timeouts = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_wrap_zero();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
